// File: rtl/mdu_sequencer_pkg.sv
// mdu_sequencer_pkg: shared encodings, FSM states and op-decoding helpers for the iterative multiply/divide unit
package mdu_sequencer_pkg;
    localparam logic [2:0] MDU_OP_MUL    = 3'b000;
    localparam logic [2:0] MDU_OP_MULH   = 3'b001;
    localparam logic [2:0] MDU_OP_MULHSU = 3'b010;
    localparam logic [2:0] MDU_OP_MULHU  = 3'b011;
    localparam logic [2:0] MDU_OP_DIV    = 3'b100;
    localparam logic [2:0] MDU_OP_DIVU   = 3'b101;
    localparam logic [2:0] MDU_OP_REM    = 3'b110;
    localparam logic [2:0] MDU_OP_REMU   = 3'b111;
    localparam logic [3:0] ALU_FN_ADD = 4'b0000;
    localparam logic [3:0] ALU_FN_SUB = 4'b0001;
    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] LAST_STEP = 6'd31;
    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;
    function automatic logic signed_a(input logic [2:0] op);
        return op == MDU_OP_MULH || op == MDU_OP_MULHSU || op == MDU_OP_DIV || op == MDU_OP_REM;
    endfunction
    function automatic logic signed_b(input logic [2:0] op);
        return op == MDU_OP_MULH || op == MDU_OP_DIV || op == MDU_OP_REM;
    endfunction
    function automatic logic is_div(input logic [2:0] op);
        return op == MDU_OP_DIV || op == MDU_OP_DIVU || op == MDU_OP_REM || op == MDU_OP_REMU;
    endfunction
    function automatic logic is_rem(input logic [2:0] op);
        return op == MDU_OP_REM || op == MDU_OP_REMU;
    endfunction
    function automatic logic is_high(input logic [2:0] op);
        return op == MDU_OP_MULH || op == MDU_OP_MULHSU || op == MDU_OP_MULHU;
    endfunction
endpackage

// File: rtl/mdu_neg64.sv
// mdu_neg64: combinational 64-bit conditional two's complement
//   i_neg  in   1   negate when high, pass through otherwise
//   i_val  in   64  value
//   o_val  out  64  i_neg ? -i_val : i_val
module mdu_neg64 (
    input  logic        i_neg,
    input  logic [63:0] i_val,
    output logic [63:0] o_val
);
    assign o_val = i_neg ? ~i_val + 64'd1 : i_val;
endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative RV32M multiply/divide using the shared external ALU for per-step add/sub
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start, i_op       request (sampled in IDLE) and RV32M op code
//   i_rs1, i_rs2        dividend/multiplicand, divisor/multiplier
//   o_busy, o_alu_req   high from PREP through DONE; core routes ALU lines from here
//   o_done, o_result    one-cycle completion pulse, result held until next done
//   o_alu_a/b/fn        ALU operands and function, zero outside ITER
//   i_alu_r, i_alu_cf   ALU result and carry (sub: 1 = no borrow)
module mdu_sequencer
    import mdu_sequencer_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    output logic        o_busy,
    output logic        o_alu_req,
    output logic        o_done,
    output logic [31:0] o_result,
    output logic [31:0] o_alu_a,
    output logic [31:0] o_alu_b,
    output logic [3:0]  o_alu_fn,
    input  logic [31:0] i_alu_r,
    input  logic        i_alu_cf
);
    state_t r_state, w_next;
    logic [2:0] r_op;
    logic [31:0] r_x, r_y, r_m, r_hi, r_lo, r_result;
    logic r_neg;
    logic [CNT_W-1:0] r_cnt;
    logic w_div, w_rem, w_sa, w_sb, w_zero, w_ovf, w_spec, w_use, w_take, w_fix;
    logic [32:0] w_rem_s;
    logic [31:0] w_spec_res, w_fix_res;
    logic [63:0] w_fix_in, w_na_in, w_na, w_nb;
    logic w_unused_nb;

    assign w_div  = is_div(r_op);
    assign w_rem  = is_rem(r_op);
    assign w_sa   = signed_a(r_op) & r_x[31];
    assign w_sb   = signed_b(r_op) & r_y[31];
    assign w_zero = r_y == 32'd0;
    assign w_ovf  = signed_b(r_op) & r_x == 32'h8000_0000 & r_y == 32'hFFFF_FFFF;
    assign w_spec = w_div & (w_zero | w_ovf);
    assign w_spec_res = w_zero ? (w_rem ? r_x : 32'hFFFF_FFFF) : (w_rem ? 32'd0 : 32'h8000_0000);
    // Divide keeps the remainder in r_hi and the quotient in r_lo; the 33rd remainder bit is r_hi[31] shifted out
    assign w_rem_s = {r_hi, r_lo[31]};
    assign w_take  = i_alu_cf | w_rem_s[32];
    assign w_use   = r_state == S_ITER & (w_div | r_lo[0]);
    assign w_fix   = r_state == S_FIX;
    assign w_fix_in = w_div ? {32'd0, w_rem ? r_hi : r_lo} : {r_hi, r_lo};
    // One negator serves PREP (|rs1|) and FIX (sign correction); the second one only takes |rs2|
    assign w_na_in  = w_fix ? w_fix_in : {32'd0, r_x};
    assign w_fix_res = is_high(r_op) ? w_na[63:32] : w_na[31:0];
    assign w_unused_nb = ^w_nb[63:32];

    mdu_neg64 u_neg_a (.i_neg(w_fix ? r_neg : w_sa), .i_val(w_na_in), .o_val(w_na));
    mdu_neg64 u_neg_b (.i_neg(w_sb), .i_val({32'd0, r_y}), .o_val(w_nb));

    assign o_busy    = r_state != S_IDLE;
    assign o_alu_req = o_busy;
    assign o_done    = r_state == S_DONE;
    assign o_result  = r_result;

    always_comb begin
        w_next   = r_state;
        o_alu_a  = '0;
        o_alu_b  = '0;
        o_alu_fn = ALU_FN_ADD;
        case (r_state)
            S_IDLE:  w_next = i_start ? S_PREP : S_IDLE;
            S_PREP:  w_next = w_spec ? S_DONE : S_ITER;
            S_ITER:  w_next = r_cnt == LAST_STEP ? S_FIX : S_ITER;
            S_FIX:   w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
        if (w_use) begin
            o_alu_a  = w_div ? w_rem_s[31:0] : r_hi;
            o_alu_b  = r_m;
            o_alu_fn = w_div ? ALU_FN_SUB : ALU_FN_ADD;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_m      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && i_start) begin
                r_op <= i_op;
                r_x  <= i_rs1;
                r_y  <= i_rs2;
            end else if (r_state == S_PREP) begin
                r_neg <= w_rem ? w_sa : w_sa ^ w_sb;
                r_m   <= w_div ? w_nb[31:0] : w_na[31:0];
                r_lo  <= w_div ? w_na[31:0] : w_nb[31:0];
                r_hi  <= '0;
                r_cnt <= '0;
                if (w_spec) r_result <= w_spec_res;
            end else if (r_state == S_ITER) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_div) begin
                    r_hi <= w_take ? i_alu_r : w_rem_s[31:0];
                    r_lo <= {r_lo[30:0], w_take};
                end else if (r_lo[0]) begin
                    {r_hi, r_lo} <= {i_alu_cf, i_alu_r, r_lo[31:1]};
                end else begin
                    {r_hi, r_lo} <= {1'b0, r_hi, r_lo[31:1]};
                end
            end else if (w_fix) begin
                r_result <= w_fix_res;
            end
        end
    end
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: table-driven and randomized checks of mdu_sequencer against an arithmetic reference model
module tb_mdu_sequencer;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [2:0] op = '0;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic busy, alu_req, done, alu_cf;
    logic [31:0] result, alu_a, alu_b, alu_r;
    logic [3:0] alu_fn;
    logic [32:0] alu_sum;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    assign alu_sum = (alu_fn == 4'b0001) ? {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1 : {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_r  = alu_sum[31:0];
    assign alu_cf = alu_sum[32];

    mdu_sequencer dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op), .i_rs1(rs1), .i_rs2(rs2),
        .o_busy(busy), .o_alu_req(alu_req), .o_done(done), .o_result(result),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_fn(alu_fn), .i_alu_r(alu_r), .i_alu_cf(alu_cf)
    );

    typedef struct { logic [2:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] res; int lat; } vec_t;
    vec_t tbl[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        int ia, ib;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        ua = $signed({32'd0, a});
        ub = $signed({32'd0, b});
        ia = a;
        ib = b;
        case (o)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            default: begin
                if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
                if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
                if (!o[0]) return o[1] ? ia % ib : ia / ib;
                return o[1] ? a % b : a / b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        return (o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 2 : 35;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        bit bad_fn = 0;
        @(negedge clk);
        start = 1'b1; op = o; rs1 = a; rs2 = b;
        @(posedge clk);
        #1;
        start = 1'b0; op = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
        lat = -1;
        res = 'x;
        for (int c = 1; c <= 60 && lat < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("prep_busy", {31'd0, busy & alu_req}, 32'd1);
                check("prep_alu_zero", alu_a | alu_b | {28'd0, alu_fn}, 32'd0);
            end
            if (alu_fn != 4'b0000 && !(alu_fn == 4'b0001 && o[2])) bad_fn = 1;
            if (done) begin
                lat = c;
                res = result;
            end
        end
        check("alu_fn_legal", {31'd0, bad_fn}, 32'd0);
    endtask

    task automatic run_and_check(input string name, input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        logic [31:0] res;
        int lat;
        run_op(o, a, b, res, lat);
        check({name, "_result"}, res, exp_res);
        check({name, "_latency"}, lat, exp_lat);
        @(negedge clk);
        check({name, "_after_done"}, {30'd0, done, busy}, 32'd0);
        check({name, "_held"}, result, exp_res);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b, res;
        logic [2:0] o;
        int dones, done_cyc;
        tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 35};
        tbl[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 35};
        tbl[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 35};
        tbl[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 35};
        tbl[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 35};
        tbl[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 35};
        tbl[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        35};
        tbl[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         35};
        tbl[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 2};
        tbl[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         2};
        tbl[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2};
        tbl[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         2};
        tbl[12] = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         35};
        tbl[13] = '{3'd7, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 35};
        tbl[14] = '{3'd5, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 35};
        tbl[15] = '{3'd0, 32'h8000_0000,  32'h8000_0000, 32'd0,         35};
        tbl[16] = '{3'd3, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 35};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_flags", {29'd0, busy, alu_req, done}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_alu", alu_a | alu_b | {28'd0, alu_fn}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++)
            run_and_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat);

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom);
            a = pick();
            b = pick();
            run_and_check($sformatf("rand%0d_op%0d", i, o), o, a, b, ref_res(o, a, b), ref_lat(o, a, b));
        end

        // start pulses while busy and on the done cycle must be ignored
        @(negedge clk);
        start = 1'b1; op = 3'd0; rs1 = 32'h0001_2345; rs2 = 32'h0000_0777;
        @(posedge clk);
        #1 start = 1'b0;
        dones = 0;
        done_cyc = -1;
        res = 'x;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (done) begin dones++; done_cyc = c; res = result; end
            if (c == 36) check("t5_idle_after_done", {31'd0, busy}, 32'd0);
            start = (c == 5 || c == 35);
            op = 3'd3; rs1 = $urandom; rs2 = $urandom;
        end
        start = 1'b0;
        check("t5_done_count", dones, 32'd1);
        check("t5_done_cycle", done_cyc, 32'd35);
        check("t5_result", res, ref_res(3'd0, 32'h0001_2345, 32'h0000_0777));
        check("t5_held", result, ref_res(3'd0, 32'h0001_2345, 32'h0000_0777));

        // reset mid-divide aborts without a done pulse
        @(negedge clk);
        start = 1'b1; op = 3'd4; rs1 = 32'hFFFF_FC18; rs2 = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        dones = 0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (done) dones++;
            if (c == 10) rst = 1'b1;
            if (c == 11) begin
                check("t6_busy_after_rst", {31'd0, busy}, 32'd0);
                check("t6_result_after_rst", result, 32'd0);
                rst = 1'b0;
            end
        end
        check("t6_no_done", dones, 32'd0);
        run_and_check("t6_new_div", 3'd4, 32'hFFFF_FC18, 32'd7, ref_res(3'd4, 32'hFFFF_FC18, 32'd7), 35);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
